// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin sequencer that shares one APB_Master user-side port among
// NUM_REQ requesters, one transfer at a time, with completion taken from the observed APB handshake.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif
`ifndef APB_STRB_WIDTH
`define APB_STRB_WIDTH 4
`endif
`ifndef APB_PROT_WIDTH
`define APB_PROT_WIDTH 3
`endif

// state  | meaning
// IDLE   | sample req, pick winner at/after rr pointer, latch its payload
// ISSUE  | transfer=1 until the master is seen in SETUP (PSEL)
// ACCESS | wait for PSEL&PENABLE&PREADY, count wait cycles for bus_hang
// RESP   | one-cycle done pulse to the winner, advance rr pointer
module apb_req_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int AW       = `APB_ADDR_WIDTH,
  parameter int DW       = `APB_DATA_WIDTH,
  parameter int SW       = `APB_STRB_WIDTH,
  parameter int PW       = `APB_PROT_WIDTH,
  parameter int HANG_CYC = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  input  logic [NUM_REQ*SW-1:0] req_strb,
  input  logic [NUM_REQ*PW-1:0] req_prot,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  bus_hang,
  output logic                  SWRITE,
  output logic [AW-1:0]         SADDR,
  output logic [DW-1:0]         SWDATA,
  output logic [SW-1:0]         SSTRB,
  output logic [PW-1:0]         SPROT,
  output logic                  transfer,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic [DW-1:0]         PRDATA
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(HANG_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACCESS, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d, win_q, win_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d, done_q, done_d;
  logic                swrite_q, swrite_d;
  logic [AW-1:0]       saddr_q, saddr_d;
  logic [DW-1:0]       swdata_q, swdata_d;
  logic [SW-1:0]       sstrb_q, sstrb_d;
  logic [PW-1:0]       sprot_q, sprot_d;
  logic                xfer_q, xfer_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic                slverr_q, slverr_d;
  logic                hang_q, hang_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [AW-1:0]       addr_a  [NUM_REQ];
  logic [DW-1:0]       wdata_a [NUM_REQ];
  logic [SW-1:0]       strb_a  [NUM_REQ];
  logic [PW-1:0]       prot_a  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = req_addr[g*AW +: AW];
    assign wdata_a[g] = req_wdata[g*DW +: DW];
    assign strb_a[g]  = req_strb[g*SW +: SW];
    assign prot_a[g]  = req_prot[g*PW +: PW];
  end

  // Rotate so bit 0 is the requester at the pointer; lowest set offset wins.
  logic [NUM_REQ-1:0]  req_rot;
  logic [IW:0]         sum;
  logic [IW-1:0]       pick;
  logic                found;

  assign req_rot = NUM_REQ'({req, req} >> ptr_q);

  always_comb begin
    found = 1'b0;
    sum   = '0;
    pick  = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (req_rot[off]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_q} + (IW+1)'(off);
      end
    end
    if (sum >= (IW+1)'(NUM_REQ)) pick = IW'(sum - (IW+1)'(NUM_REQ));
    else                         pick = sum[IW-1:0];
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    swrite_d = swrite_q;
    saddr_d  = saddr_q;
    swdata_d = swdata_q;
    sstrb_d  = sstrb_q;
    sprot_d  = sprot_q;
    xfer_d   = xfer_q;
    rdata_d  = rdata_q;
    slverr_d = slverr_q;
    hang_d   = hang_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          win_d    = pick;
          gnt_d    = NUM_REQ'(1) << pick;
          swrite_d = req_write[pick];
          saddr_d  = addr_a[pick];
          swdata_d = wdata_a[pick];
          sstrb_d  = strb_a[pick];
          sprot_d  = prot_a[pick];
          xfer_d   = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (PSEL) begin
          xfer_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (PSEL && PENABLE && PREADY) begin
          rdata_d  = PRDATA;
          slverr_d = PSLVERR;
          done_d   = gnt_q;
          state_d  = S_RESP;
        end else if (cnt_q != CW'(HANG_CYC)) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == CW'(HANG_CYC)) hang_d = 1'b1;
        end
      end
      S_RESP: begin
        gnt_d   = '0;
        ptr_d   = (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      swrite_q <= 1'b0;
      saddr_q  <= '0;
      swdata_q <= '0;
      sstrb_q  <= '0;
      sprot_q  <= '0;
      xfer_q   <= 1'b0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
      hang_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      swrite_q <= swrite_d;
      saddr_q  <= saddr_d;
      swdata_q <= swdata_d;
      sstrb_q  <= sstrb_d;
      sprot_q  <= sprot_d;
      xfer_q   <= xfer_d;
      rdata_q  <= rdata_d;
      slverr_q <= slverr_d;
      hang_q   <= hang_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_slverr = slverr_q;
  assign bus_hang   = hang_q;
  assign SWRITE     = swrite_q;
  assign SADDR      = saddr_q;
  assign SWDATA     = swdata_q;
  assign SSTRB      = sstrb_q;
  assign SPROT      = sprot_q;
  assign transfer   = xfer_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: an APB master/slave model on the bus side, directed vector table,
// multi-cycle corner sequences and a randomized round-robin scoreboard.
`timescale 1ns/1ps
module tb_apb_req_arbiter;
  localparam int NR = 4, AW = 32, DW = 32, SW = 4, PW = 3, HC = 32;

  logic              PCLK = 1'b0;
  logic              PRESETn = 1'b0;
  logic [NR-1:0]     req = '0, req_write = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*DW-1:0]  req_wdata = '0;
  logic [NR*SW-1:0]  req_strb = '0;
  logic [NR*PW-1:0]  req_prot = '0;
  logic [NR-1:0]     gnt, done;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_slverr, bus_hang, SWRITE, transfer;
  logic [AW-1:0]     SADDR;
  logic [DW-1:0]     SWDATA;
  logic [SW-1:0]     SSTRB;
  logic [PW-1:0]     SPROT;
  logic              PSEL, PENABLE, PREADY, PSLVERR;
  logic [DW-1:0]     PRDATA;

  apb_req_arbiter #(.NUM_REQ(NR), .AW(AW), .DW(DW), .SW(SW), .PW(PW), .HANG_CYC(HC)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .req(req), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot), .gnt(gnt), .done(done),
    .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr), .bus_hang(bus_hang), .SWRITE(SWRITE),
    .SADDR(SADDR), .SWDATA(SWDATA), .SSTRB(SSTRB), .SPROT(SPROT), .transfer(transfer),
    .PSEL(PSEL), .PENABLE(PENABLE), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA));

  always #5 PCLK = ~PCLK;

  int n_vec = 0, n_err = 0, cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // APB master + slave model: SETUP one cycle after transfer, ACCESS waits slv_wait cycles.
  int              slv_wait = 0;
  bit              slv_err = 1'b0;
  int              wcnt = 0;
  logic [31:0]     slv_mem [256] = '{default: '0};
  int              bus_cnt = 0;
  logic [AW-1:0]   bus_addr = '0;
  logic            bus_write = 1'b0;
  logic [DW-1:0]   bus_wdata = '0;
  logic [SW-1:0]   bus_strb = '0;
  logic [PW-1:0]   bus_prot = '0;

  function automatic logic [31:0] slv_merge(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  assign PREADY  = PSEL && PENABLE && (wcnt >= slv_wait);
  assign PSLVERR = PREADY && slv_err;
  assign PRDATA  = (PSEL && PENABLE && !SWRITE) ? slv_mem[SADDR[7:0]] : '0;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PSEL <= 1'b0; PENABLE <= 1'b0; wcnt <= 0;
    end else if (!PSEL) begin
      PSEL <= transfer; PENABLE <= 1'b0;
    end else if (!PENABLE) begin
      PENABLE <= 1'b1; wcnt <= 0;
    end else if (PREADY) begin
      PSEL <= 1'b0; PENABLE <= 1'b0;
      if (SWRITE) slv_mem[SADDR[7:0]] <= slv_merge(slv_mem[SADDR[7:0]], SWDATA, SSTRB);
      bus_cnt <= bus_cnt + 1;
      bus_addr <= SADDR; bus_write <= SWRITE; bus_wdata <= SWDATA;
      bus_strb <= SSTRB; bus_prot <= SPROT;
    end else begin
      wcnt <= wcnt + 1;
    end
  end

  // Global invariants: one-hot grant, done inside grant, at least one idle cycle before a grant.
  logic [NR-1:0] gnt_prev = '0;
  int last_done = -100;
  always @(negedge PCLK) begin
    if (PRESETn) begin
      chk("gnt_onehot", $onehot0(gnt), 1);
      chk("done_in_gnt", $onehot0(done) && ((done & ~gnt) == '0), 1);
      if (gnt != '0 && gnt_prev == '0) chk("idle_gap", (cyc - last_done) >= 2, 1);
      if (done != '0) last_done = cyc;
    end
    gnt_prev = gnt;
  end

  // Reference model memory: byte-lane masking written as plain arithmetic.
  logic [31:0] ref_mem [256] = '{default: '0};
  function automatic logic [31:0] ref_write(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [3:0] st);
    logic [31:0] m;
    m = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
    return (old & ~m) | (wd & m);
  endfunction

  task automatic set_payload(input int i, input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [SW-1:0] s, input logic [PW-1:0] p);
    req_write[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_strb[i*SW +: SW] = s;
    req_prot[i*PW +: PW] = p;
  endtask

  task automatic wait_gnt(input int idx, output int at);
    at = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge PCLK);
      if (gnt[idx]) begin at = cyc; break; end
    end
    if (at < 0) timeout_fail("wait_gnt");
  endtask

  task automatic wait_done(input int budget, output logic [NR-1:0] d, output int at);
    d = '0;
    at = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge PCLK);
      if (done != '0) begin d = done; at = cyc; break; end
    end
    if (at < 0) timeout_fail("wait_done");
  endtask

  typedef struct {
    int          idx;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          wait_c;
    logic        err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vt[5];

  // Latency: done edge minus grant edge; a zero-wait slave gives 3, each wait cycle adds 1.
  task automatic run_vec(input vec_t v);
    int tg, td, n0;
    logic [NR-1:0] d;
    slv_wait = v.wait_c;
    slv_err = v.err;
    set_payload(v.idx, v.wr, v.addr, v.wdata, v.strb, v.prot);
    n0 = bus_cnt;
    req[v.idx] = 1'b1;
    wait_gnt(v.idx, tg);
    req[v.idx] = 1'b0;
    set_payload(v.idx, ~v.wr, ~v.addr, ~v.wdata, ~v.strb, ~v.prot);
    wait_done(40, d, td);
    chk("vec_done", d, 64'(1) << v.idx);
    chk("vec_latency", td - tg, v.exp_lat);
    chk("vec_rdata", rsp_rdata, v.exp_rdata);
    chk("vec_slverr", rsp_slverr, v.err);
    chk("vec_bus_cnt", bus_cnt - n0, 1);
    chk("vec_bus_addr", bus_addr, v.addr);
    chk("vec_bus_write", bus_write, v.wr);
    chk("vec_bus_prot", bus_prot, v.prot);
    if (v.wr) begin
      chk("vec_bus_wdata", bus_wdata, v.wdata);
      chk("vec_bus_strb", bus_strb, v.strb);
      ref_mem[v.addr[7:0]] = ref_write(ref_mem[v.addr[7:0]], v.wdata, v.strb);
    end
    @(negedge PCLK);
    chk("vec_done_pulse", done, 0);
    chk("vec_gnt_drop", gnt, 0);
    @(negedge PCLK);
    chk("vec_rsp_hold", rsp_rdata, v.exp_rdata);
  endtask

  logic        pw [NR];
  logic [31:0] pa [NR], pd [NR];
  logic [3:0]  ps [NR];
  logic [2:0]  pp [NR];

  initial begin
    int tg, td, ptr_m, exp_w;
    logic [NR-1:0] d, mask;
    logic [31:0] exp_rd;

    vt[0] = '{idx: 0, wr: 1, addr: 32'h10, wdata: 32'hA5A5_A5A5, strb: 4'hF, prot: 3'd0,
              wait_c: 0, err: 0, exp_rdata: 32'h0, exp_lat: 3};
    vt[1] = '{idx: 2, wr: 0, addr: 32'h10, wdata: 32'h0, strb: 4'h0, prot: 3'd1,
              wait_c: 3, err: 0, exp_rdata: 32'hA5A5_A5A5, exp_lat: 6};
    vt[2] = '{idx: 1, wr: 1, addr: 32'h20, wdata: 32'h1234_5678, strb: 4'h3, prot: 3'd2,
              wait_c: 1, err: 1, exp_rdata: 32'h0, exp_lat: 4};
    vt[3] = '{idx: 3, wr: 0, addr: 32'h20, wdata: 32'h0, strb: 4'h0, prot: 3'd5,
              wait_c: 0, err: 0, exp_rdata: 32'h0000_5678, exp_lat: 3};
    vt[4] = '{idx: 1, wr: 0, addr: 32'h10, wdata: 32'h0, strb: 4'h0, prot: 3'd7,
              wait_c: 2, err: 1, exp_rdata: 32'hA5A5_A5A5, exp_lat: 5};

    // Reset state
    repeat (2) @(negedge PCLK);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_transfer", transfer, 0);
    chk("rst_hang", bus_hang, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_slverr", rsp_slverr, 0);
    chk("rst_saddr", SADDR, 0);
    chk("rst_swrite", SWRITE, 0);
    PRESETn = 1'b1;

    // All four requesting from reset, held: pointer starts at 0
    for (int i = 0; i < NR; i++) set_payload(i, 1'b0, 32'h40, 32'h0, 4'h0, 3'(i));
    slv_wait = 0;
    slv_err = 1'b0;
    req = '1;
    for (int k = 0; k < 5; k++) begin
      wait_done(40, d, td);
      chk("rr_order", d, 64'(1) << (k % NR));
    end
    req = '0;
    repeat (3) @(negedge PCLK);
    chk("rr_idle_after", gnt, 0);

    // Directed vector table
    for (int i = 0; i < 5; i++) run_vec(vt[i]);

    // Randomized masks against a round-robin model
    ptr_m = (vt[4].idx + 1) % NR;
    for (int r = 0; r < 40; r++) begin
      mask = NR'($urandom_range(1, (1 << NR) - 1));
      for (int i = 0; i < NR; i++) begin
        pw[i] = 1'($urandom_range(0, 1));
        pa[i] = 32'h80 + 32'(4 * $urandom_range(0, 7));
        pd[i] = $urandom;
        ps[i] = 4'($urandom_range(1, 15));
        pp[i] = 3'($urandom_range(0, 7));
        set_payload(i, pw[i], pa[i], pd[i], ps[i], pp[i]);
      end
      slv_wait = $urandom_range(0, 3);
      slv_err = 1'($urandom_range(0, 1));
      req = mask;
      exp_w = -1;
      for (int o = 0; o < NR; o++)
        if (exp_w < 0 && mask[(ptr_m + o) % NR]) exp_w = (ptr_m + o) % NR;
      exp_rd = pw[exp_w] ? 32'h0 : ref_mem[pa[exp_w][7:0]];
      wait_done(40, d, td);
      chk("rand_winner", d, 64'(1) << exp_w);
      chk("rand_addr", bus_addr, pa[exp_w]);
      chk("rand_write", bus_write, pw[exp_w]);
      chk("rand_rdata", rsp_rdata, exp_rd);
      chk("rand_slverr", rsp_slverr, slv_err);
      if (pw[exp_w]) ref_mem[pa[exp_w][7:0]] = ref_write(ref_mem[pa[exp_w][7:0]], pd[exp_w], ps[exp_w]);
      ptr_m = (exp_w + 1) % NR;
    end
    req = '0;
    repeat (3) @(negedge PCLK);

    // Hang detection: PREADY low for HC+5 access cycles
    slv_wait = HC + 5;
    slv_err = 1'b0;
    set_payload(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'd0);
    req[0] = 1'b1;
    wait_gnt(0, tg);
    req[0] = 1'b0;
    while (cyc < tg + 1 + HC) @(negedge PCLK);
    chk("hang_before_limit", bus_hang, 0);
    @(negedge PCLK);
    chk("hang_at_limit", bus_hang, 1);
    wait_done(HC + 20, d, td);
    chk("hang_done", d, 1);
    chk("hang_latency", td - tg, 3 + HC + 5);
    chk("hang_rdata", rsp_rdata, ref_mem[8'h10]);
    repeat (3) @(negedge PCLK);
    chk("hang_sticky", bus_hang, 1);

    // Reset in the middle of an ACCESS wait
    slv_wait = 10;
    set_payload(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'd0);
    req[0] = 1'b1;
    wait_gnt(0, tg);
    req[0] = 1'b0;
    td = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge PCLK);
      if (PENABLE) begin td = k; break; end
    end
    if (td < 0) timeout_fail("wait_access");
    @(negedge PCLK);
    #2 PRESETn = 1'b0;
    #1;
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_transfer", transfer, 0);
    chk("mid_rst_hang", bus_hang, 0);
    chk("mid_rst_saddr", SADDR, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    slv_wait = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge PCLK);
      chk("post_rst_no_done", done, 0);
    end
    set_payload(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'd0);
    set_payload(3, 1'b0, 32'h20, 32'h0, 4'h0, 3'd0);
    req = 4'b1001;
    wait_done(40, d, td);
    req = '0;
    chk("post_rst_winner", d, 1);
    chk("post_rst_rdata", rsp_rdata, ref_mem[8'h10]);
    repeat (3) @(negedge PCLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
